uart_tx_fifo: RTL and testbench

//  Parametrised UART transmitter with a write-side FIFO and zero-gap back-to-back framing.

---
 rtl/uart_tx_fifo.sv | 245 ++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : UART transmitter fed by a small write-side FIFO. Frames are
//               sent back-to-back with no idle gap while words are queued.
//               Frame shape (data width, parity, stop bits, bit order) is
//               fixed by parameters; parity sense is latched per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 14,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 1,
    parameter int STOP_BITS    = 1,
    parameter int MSB_FIRST    = 1,
    parameter int DEPTH        = 4
) (
    input  logic                         clk_3125,
    input  logic                         rst_n,
    input  logic                         parity_type,
    input  logic                         wr_en,
    input  logic [DATA_BITS-1:0]         wr_data,
    output logic                         wr_full,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         tx,
    output logic                         tx_done,
    output logic                         busy
);

    localparam int c_CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int c_IDX_W  = $clog2(DATA_BITS);
    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_FCNT_W = $clog2(DEPTH + 1);

    localparam logic [c_CNT_W-1:0]  c_CNT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(DATA_BITS - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_ONE   = c_IDX_W'(1);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [c_FCNT_W-1:0] c_FCNT_ONE  = c_FCNT_W'(1);
    localparam logic [c_FCNT_W-1:0] c_FCNT_FULL = c_FCNT_W'(DEPTH);
    localparam logic                c_STOP_LAST = (STOP_BITS == 2);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_FCNT_W-1:0]  r_count;
    logic [c_FCNT_W-1:0]  w_count_next;
    logic                 r_full;
    logic                 w_push;
    logic                 w_pop;
    logic [DATA_BITS-1:0] w_head;

    // ------------------------------------------------------------------
    // Transmit datapath and state
    // ------------------------------------------------------------------
    logic [2:0]           r_state;
    logic [c_CNT_W-1:0]   r_clk_cnt;
    logic [c_IDX_W-1:0]   r_bit_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_tx;
    logic                 r_tx_done;
    logic                 r_busy;
    logic                 w_bit_end;
    logic                 w_frame_end;
    logic                 w_out_bit;
    logic [DATA_BITS-1:0] w_shift_next;

    // The full flag is registered, so a push in the same cycle as a pop from
    // a full FIFO is still dropped.
    assign w_push = wr_en && !r_full;
    assign w_head = r_mem[r_rd_ptr];

    assign w_bit_end   = (r_clk_cnt == c_CNT_LAST);
    assign w_frame_end = (r_state == c_STOP) && w_bit_end && (r_stop_idx == c_STOP_LAST);
    // A word leaves the FIFO either from idle or on the last stop-bit cycle,
    // which is what makes consecutive frames gapless.
    assign w_pop = (r_count != '0) && ((r_state == c_IDLE) || w_frame_end);

    // Next occupancy from this cycle's push/pop pair
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_FCNT_ONE;
            2'b01:   w_count_next = r_count - c_FCNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // Bit order selection: the outgoing bit is always at the shift end
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_out_bit    = r_shift[DATA_BITS-1];
            assign w_shift_next = {r_shift[DATA_BITS-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_out_bit    = r_shift[0];
            assign w_shift_next = {1'b0, r_shift[DATA_BITS-1:1]};
        end
    endgenerate

    // Storage array write; contents need no reset
    always_ff @(posedge clk_3125) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers, occupancy and full flag
    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_FCNT_FULL);
        end
    end

    // Frame sequencer: start, data, optional parity, stop bits
    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_tx       <= 1'b1;
            r_tx_done  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_tx      <= 1'b1;
                    r_busy    <= 1'b0;
                    r_clk_cnt <= '0;
                    if (w_pop) begin
                        r_shift   <= w_head;
                        r_par     <= (^w_head) ^ parity_type;
                        r_tx      <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= c_START;
                    end
                end
                c_START: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= w_out_bit;
                        r_shift   <= w_shift_next;
                        r_state   <= c_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + c_CNT_ONE;
                    end
                end
                c_DATA: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == c_IDX_LAST) begin
                            if (PARITY_EN != 0) begin
                                r_tx    <= r_par;
                                r_state <= c_PARITY;
                            end else begin
                                r_tx       <= 1'b1;
                                r_stop_idx <= 1'b0;
                                r_state    <= c_STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + c_IDX_ONE;
                            r_tx      <= w_out_bit;
                            r_shift   <= w_shift_next;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + c_CNT_ONE;
                    end
                end
                c_PARITY: begin
                    if (w_bit_end) begin
                        r_clk_cnt  <= '0;
                        r_tx       <= 1'b1;
                        r_stop_idx <= 1'b0;
                        r_state    <= c_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + c_CNT_ONE;
                    end
                end
                c_STOP: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_stop_idx == c_STOP_LAST) begin
                            r_tx_done <= 1'b1;
                            if (w_pop) begin
                                r_shift <= w_head;
                                r_par   <= (^w_head) ^ parity_type;
                                r_tx    <= 1'b0;
                                r_state <= c_START;
                            end else begin
                                r_tx    <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= c_IDLE;
                            end
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign wr_full    = r_full;
    assign fifo_count = r_count;
    assign tx         = r_tx;
    assign tx_done    = r_tx_done;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo. Two instances share the
//               stimulus: one MSB-first (defaults), one LSB-first.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int CPB       = 14;
    localparam int NBITS     = 11;
    localparam int FRAME_LEN = CPB * NBITS;
    localparam int DEPTH     = 4;

    logic       clk_3125    = 1'b0;
    logic       rst_n       = 1'b1;
    logic       parity_type = 1'b0;
    logic       wr_en       = 1'b0;
    logic [7:0] wr_data     = 8'h00;

    logic       tx_a, done_a, busy_a, full_a;
    logic [2:0] cnt_a;
    logic       tx_b, done_b, busy_b, full_b;
    logic [2:0] cnt_b;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] exp_words [$];

    always #160 clk_3125 = ~clk_3125;

    uart_tx_fifo dut_a (
        .clk_3125    (clk_3125),
        .rst_n       (rst_n),
        .parity_type (parity_type),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_full     (full_a),
        .fifo_count  (cnt_a),
        .tx          (tx_a),
        .tx_done     (done_a),
        .busy        (busy_a)
    );

    uart_tx_fifo #(.MSB_FIRST(0)) dut_b (
        .clk_3125    (clk_3125),
        .rst_n       (rst_n),
        .parity_type (parity_type),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_full     (full_b),
        .fifo_count  (cnt_b),
        .tx          (tx_b),
        .tx_done     (done_b),
        .busy        (busy_b)
    );

    // Reference frame: bit levels in line order, index 0 = start bit
    function automatic logic [NBITS-1:0] exp_frame(input logic [7:0] w, input logic odd,
                                                   input bit msb);
        logic [NBITS-1:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[1+i] = msb ? w[7-i] : w[i];
        end
        f[9]  = ((($countones(w)) % 2) == 1) ^ odd;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic push(input logic [7:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        @(negedge clk_3125);
        wr_en   = 1'b0;
        wr_data = 8'($urandom);
    endtask

    // Follow n frames cycle by cycle from the first start-bit cycle
    task automatic run_frames(input string name, input int n, input logic odd);
        int t;
        int bad_a, bad_b, bad_busy, bad_done, fa, fb, fd;
        logic ga, gb;
        logic edone;
        logic [7:0] w;
        logic [NBITS-1:0] ea, eb;
        t = 0;
        while (tx_a !== 1'b0 && t < 400) begin
            @(negedge clk_3125);
            t++;
        end
        n_total++;
        if (tx_a !== 1'b0) begin
            $display("FAIL %s_start: tx=%b, required 0 within 400 cycles", name, tx_a);
            exp_words.delete();
            return;
        end
        n_pass++;
        for (int f = 0; f < n; f++) begin
            w  = (exp_words.size() > 0) ? exp_words.pop_front() : 8'h00;
            ea = exp_frame(w, odd, 1'b1);
            eb = exp_frame(w, odd, 1'b0);
            bad_a = 0; bad_b = 0; bad_busy = 0; bad_done = 0;
            fa = 0; fb = 0; fd = 0; ga = 1'b0; gb = 1'b0;
            for (int k = 0; k < FRAME_LEN; k++) begin
                if (tx_a !== ea[k/CPB]) begin
                    if (bad_a == 0) begin fa = k; ga = tx_a; end
                    bad_a++;
                end
                if (tx_b !== eb[k/CPB]) begin
                    if (bad_b == 0) begin fb = k; gb = tx_b; end
                    bad_b++;
                end
                if ({busy_a, busy_b} !== 2'b11) bad_busy++;
                edone = (k == 0) && (f > 0);
                if (done_a !== edone || done_b !== edone) begin
                    if (bad_done == 0) fd = k;
                    bad_done++;
                end
                @(negedge clk_3125);
            end
            n_total++;
            if (bad_a != 0)
                $display("FAIL %s_msb_bits frame %0d word %h: %0d wrong cycles, first at %0d tx=%b required %b",
                         name, f, w, bad_a, fa, ga, ea[fa/CPB]);
            else n_pass++;
            n_total++;
            if (bad_b != 0)
                $display("FAIL %s_lsb_bits frame %0d word %h: %0d wrong cycles, first at %0d tx=%b required %b",
                         name, f, w, bad_b, fb, gb, eb[fb/CPB]);
            else n_pass++;
            n_total++;
            if (bad_busy != 0)
                $display("FAIL %s_busy frame %0d: busy low on %0d cycles, required 0", name, f, bad_busy);
            else n_pass++;
            n_total++;
            if (bad_done != 0)
                $display("FAIL %s_done frame %0d: tx_done wrong on %0d cycles (first at %0d), required 0",
                         name, f, bad_done, fd);
            else n_pass++;
        end
        n_total++;
        if ({done_a, done_b, tx_a, tx_b, busy_a, busy_b} !== 6'b111100)
            $display("FAIL %s_end: done/tx/busy=%b, required 111100", name,
                     {done_a, done_b, tx_a, tx_b, busy_a, busy_b});
        else n_pass++;
        @(negedge clk_3125);
        n_total++;
        if ({done_a, done_b} !== 2'b00)
            $display("FAIL %s_done_width: tx_done=%b, required 00", name, {done_a, done_b});
        else n_pass++;
    endtask

    task automatic test_reset();
        #5 rst_n = 1'b0;
        repeat (5) @(negedge clk_3125);
        n_total++;
        if ({tx_a, done_a, busy_a, full_a, cnt_a} !== 7'b1000000)
            $display("FAIL reset_a: tx,done,busy,full,count=%b, required 1000000",
                     {tx_a, done_a, busy_a, full_a, cnt_a});
        else n_pass++;
        n_total++;
        if ({tx_b, done_b, busy_b, full_b, cnt_b} !== 7'b1000000)
            $display("FAIL reset_b: tx,done,busy,full,count=%b, required 1000000",
                     {tx_b, done_b, busy_b, full_b, cnt_b});
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk_3125);
    endtask

    task automatic test_single_frame();
        parity_type = 1'b0;
        exp_words.push_back(8'hA5);
        push(8'hA5);
        n_total++;
        if ({tx_a, tx_b, cnt_a} !== 5'b11001)
            $display("FAIL latency_pre: tx_a,tx_b,count=%b, required 11001", {tx_a, tx_b, cnt_a});
        else n_pass++;
        @(negedge clk_3125);
        n_total++;
        if ({tx_a, tx_b, busy_a, cnt_a} !== 6'b001000)
            $display("FAIL latency_post: tx_a,tx_b,busy,count=%b, required 001000",
                     {tx_a, tx_b, busy_a, cnt_a});
        else n_pass++;
        run_frames("even_a5", 1, 1'b0);
        parity_type = 1'b1;
        exp_words.push_back(8'hA5);
        push(8'hA5);
        run_frames("odd_a5", 1, 1'b1);
    endtask

    task automatic test_random_frames();
        int n;
        logic odd;
        logic [7:0] ws [$];
        repeat (5) begin
            n   = $urandom_range(1, 3);
            odd = 1'($urandom_range(0, 1));
            parity_type = odd;
            ws.delete();
            for (int i = 0; i < n; i++) begin
                ws.push_back(8'($urandom));
                exp_words.push_back(ws[i]);
            end
            fork
                begin
                    for (int i = 0; i < n; i++) push(ws[i]);
                    if (n == 1) begin
                        @(negedge clk_3125);
                        parity_type = ~odd;
                    end
                end
                run_frames("random", n, odd);
            join
            repeat ($urandom_range(0, 5)) @(negedge clk_3125);
        end
    endtask

    task automatic test_back_to_back();
        logic odd;
        odd = 1'($urandom_range(0, 1));
        parity_type = odd;
        exp_words.push_back(8'h01);
        exp_words.push_back(8'h02);
        exp_words.push_back(8'h03);
        fork
            begin
                push(8'h01);
                push(8'h02);
                push(8'h03);
                n_total++;
                if ({cnt_a, cnt_b} !== {3'd2, 3'd2})
                    $display("FAIL b2b_count: fifo_count a=%0d b=%0d, required 2", cnt_a, cnt_b);
                else n_pass++;
            end
            run_frames("b2b", 3, odd);
        join
    endtask

    task automatic test_overflow();
        logic odd;
        logic [7:0] ws [$];
        int accepted;
        odd = 1'($urandom_range(0, 1));
        parity_type = odd;
        for (int i = 0; i < 6; i++) ws.push_back(8'($urandom));
        // From idle the first word leaves for the line one cycle after it is
        // pushed, so a burst fits DEPTH queued words plus the one in flight.
        accepted = (6 < DEPTH + 1) ? 6 : DEPTH + 1;
        for (int i = 0; i < accepted; i++) exp_words.push_back(ws[i]);
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    push(ws[i]);
                    if (i == 3) begin
                        n_total++;
                        if ({full_a, full_b, cnt_a} !== {2'b00, 3'd3})
                            $display("FAIL ovf_before_full: full=%b count=%0d, required full=00 count=3",
                                     {full_a, full_b}, cnt_a);
                        else n_pass++;
                    end
                    if (i >= 4) begin
                        n_total++;
                        if ({full_a, full_b, cnt_a, cnt_b} !== {2'b11, 3'd4, 3'd4})
                            $display("FAIL ovf_full push %0d: full=%b count=%0d/%0d, required full=11 count=4",
                                     i + 1, {full_a, full_b}, cnt_a, cnt_b);
                        else n_pass++;
                    end
                end
            end
            run_frames("overflow", accepted, odd);
        join
    endtask

    task automatic test_reset_mid_frame();
        logic odd;
        logic [7:0] w;
        int bad;
        odd = 1'($urandom_range(0, 1));
        parity_type = odd;
        push(8'($urandom));
        push(8'($urandom));
        repeat (40) @(negedge clk_3125);
        n_total++;
        if ({busy_a, busy_b, cnt_a} !== {2'b11, 3'd1})
            $display("FAIL midrst_pre: busy=%b count=%0d, required busy=11 count=1", {busy_a, busy_b}, cnt_a);
        else n_pass++;
        #20 rst_n = 1'b0;
        #1;
        n_total++;
        if ({tx_a, busy_a, done_a, full_a, cnt_a} !== 7'b1000000)
            $display("FAIL midrst_async_a: tx,busy,done,full,count=%b, required 1000000",
                     {tx_a, busy_a, done_a, full_a, cnt_a});
        else n_pass++;
        n_total++;
        if ({tx_b, busy_b, done_b, full_b, cnt_b} !== 7'b1000000)
            $display("FAIL midrst_async_b: tx,busy,done,full,count=%b, required 1000000",
                     {tx_b, busy_b, done_b, full_b, cnt_b});
        else n_pass++;
        repeat (3) @(negedge clk_3125);
        rst_n = 1'b1;
        bad = 0;
        repeat (200) begin
            @(negedge clk_3125);
            if ({tx_a, tx_b, done_a, done_b, busy_a, busy_b} !== 6'b110000) bad++;
        end
        n_total++;
        if (bad != 0)
            $display("FAIL midrst_quiet: %0d cycles with activity after reset, required 0", bad);
        else n_pass++;
        exp_words.delete();
        w = 8'($urandom);
        exp_words.push_back(w);
        push(w);
        run_frames("after_rst", 1, odd);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_random_frames();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #(320 * 40000);
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
